// File: rtl/dcache_mem_responder.sv
// Memory-side responder for the dcache: accepts one load/store per cycle,
// grants a nonzero tag at once and returns load data a fixed latency later.
module dcache_mem_responder #(
    parameter int MEM_LATENCY = 3,
    parameter int MEM_LINES   = 64,
    parameter int LINE_W      = 64
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [1:0]        proc2mem_command,
    input  logic [63:0]       proc2mem_addr,
    input  logic [LINE_W-1:0] proc2mem_data,
    output logic [3:0]        mem2proc_response,
    output logic [LINE_W-1:0] mem2proc_data,
    output logic [3:0]        mem2proc_tag
);

    localparam int IW = $clog2(MEM_LINES);
    localparam logic [63:0] ADDR_LIMIT = 64'(MEM_LINES) * 64'd8;

    typedef enum logic [1:0] {
        CMD_NONE  = 2'd0,
        CMD_LOAD  = 2'd1,
        CMD_STORE = 2'd2,
        CMD_RSVD  = 2'd3
    } cmd_e;

    logic [LINE_W-1:0] lines [MEM_LINES];
    logic              slot_valid [MEM_LATENCY];
    logic [3:0]        slot_tag   [MEM_LATENCY];
    logic [LINE_W-1:0] slot_data  [MEM_LATENCY];

    logic [3:0]        next_tag;
    logic [IW-1:0]     line_idx;
    logic              is_load;
    logic              is_store;
    logic              in_range;
    logic              accept;
    logic              load_accept;

    // Decode the command and decide whether it is granted a tag this cycle.
    always_comb begin
        is_load           = 1'b0;
        is_store          = 1'b0;
        unique case (cmd_e'(proc2mem_command))
            CMD_LOAD:  is_load  = 1'b1;
            CMD_STORE: is_store = 1'b1;
            default:   ;
        endcase
        in_range          = proc2mem_addr < ADDR_LIMIT;
        line_idx          = proc2mem_addr[IW+2:3];
        accept            = !reset && (is_load || is_store) && in_range;
        load_accept       = accept && is_load;
        mem2proc_response = accept ? next_tag : 4'd0;
    end

    // Tag counter cycles 1..15, never issuing 0.
    always_ff @(posedge clock) begin
        if (reset) begin
            next_tag <= 4'd1;
        end else if (accept) begin
            next_tag <= (next_tag == 4'd15) ? 4'd1 : next_tag + 4'd1;
        end
    end

    // Backing store: cleared on reset, written by accepted stores.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < MEM_LINES; i++) begin
                lines[i] <= '0;
            end
        end else if (accept && is_store) begin
            lines[line_idx] <= proc2mem_data;
        end
    end

    // Return pipeline: loads snapshot their line at accept and shift out in order.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < MEM_LATENCY; i++) begin
                slot_valid[i] <= 1'b0;
                slot_tag[i]   <= 4'd0;
                slot_data[i]  <= '0;
            end
        end else begin
            slot_valid[0] <= load_accept;
            slot_tag[0]   <= load_accept ? next_tag : 4'd0;
            slot_data[0]  <= load_accept ? lines[line_idx] : '0;
            for (int i = 1; i < MEM_LATENCY; i++) begin
                slot_valid[i] <= slot_valid[i-1];
                slot_tag[i]   <= slot_tag[i-1];
                slot_data[i]  <= slot_data[i-1];
            end
        end
    end

    // Present the oldest slot; an empty slot reads as all zeros.
    always_comb begin
        mem2proc_tag  = 4'd0;
        mem2proc_data = '0;
        if (slot_valid[MEM_LATENCY-1]) begin
            mem2proc_tag  = slot_tag[MEM_LATENCY-1];
            mem2proc_data = slot_data[MEM_LATENCY-1];
        end
    end

endmodule

// File: tb/tb_dcache_mem_responder.sv
// Bench for dcache_mem_responder: directed vector table, a wrap sequence
// and random traffic, all checked against a queue-based memory model.
module tb_dcache_mem_responder;

    localparam int LAT = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  cmd = 2'd0;
    logic [63:0] addr = '0;
    logic [63:0] wdata = '0;
    logic [3:0]  resp;
    logic [63:0] rdata;
    logic [3:0]  rtag;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    dcache_mem_responder #(
        .MEM_LATENCY(LAT),
        .MEM_LINES(64),
        .LINE_W(64)
    ) dut (
        .clock(clk),
        .reset(reset),
        .proc2mem_command(cmd),
        .proc2mem_addr(addr),
        .proc2mem_data(wdata),
        .mem2proc_response(resp),
        .mem2proc_data(rdata),
        .mem2proc_tag(rtag)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        logic [3:0]  tag;
        logic [63:0] data;
    } ret_t;

    ret_t        pend[$];
    logic [63:0] mmem [64];
    logic [3:0]  mtag;

    typedef struct {
        bit          rst;
        logic [1:0]  cmd;
        logic [63:0] addr;
        logic [63:0] data;
        logic [3:0]  resp;
        logic [3:0]  tag;
        logic [63:0] rdata;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        pend.delete();
        mtag = 4'd1;
        for (int i = 0; i < 64; i++) mmem[i] = '0;
    endtask

    task automatic cycle(input bit rst, input logic [1:0] c,
                         input logic [63:0] a, input logic [63:0] d,
                         output logic [3:0] r, output logic [3:0] t,
                         output logic [63:0] q);
        logic        acc;
        logic [3:0]  er;
        logic [3:0]  et;
        logic [63:0] ed;
        int          idx;
        @(posedge clk);
        #1;
        reset = rst;
        cmd   = c;
        addr  = a;
        wdata = d;
        cyc++;
        @(negedge clk);
        acc = !rst && (c == 2'd1 || c == 2'd2) && (a < 64'd512);
        er  = acc ? mtag : 4'd0;
        et  = 4'd0;
        ed  = '0;
        if (pend.size() > 0 && pend[0].due == cyc) begin
            et = pend[0].tag;
            ed = pend[0].data;
            void'(pend.pop_front());
        end
        chk("model_resp", {60'd0, resp}, {60'd0, er});
        chk("model_tag", {60'd0, rtag}, {60'd0, et});
        chk("model_data", rdata, ed);
        r = resp;
        t = rtag;
        q = rdata;
        if (rst) begin
            model_reset();
        end else if (acc) begin
            idx = int'(a >> 3);
            if (c == 2'd2) mmem[idx] = d;
            else pend.push_back('{cyc + LAT, mtag, mmem[idx]});
            mtag = (mtag == 4'd15) ? 4'd1 : mtag + 4'd1;
        end
    endtask

    function automatic void add(input bit rs, input logic [1:0] c,
                                input logic [63:0] a, input logic [63:0] d,
                                input logic [3:0] r, input logic [3:0] t,
                                input logic [63:0] q);
        tbl.push_back('{rs, c, a, d, r, t, q});
    endfunction

    initial begin
        logic [3:0]  r;
        logic [3:0]  t;
        logic [63:0] q;
        logic [63:0] ra;
        logic [1:0]  rc;

        repeat (2) @(posedge clk);
        model_reset();

        add(1, 0, 0, 0, 0, 0, 0);
        add(1, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0);
        add(0, 1, 64'h10, 0, 1, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 1, 0);
        add(0, 0, 0, 0, 0, 0, 0);
        add(1, 0, 0, 0, 0, 0, 0);
        add(0, 2, 64'h18, 64'hcccc, 1, 0, 0);
        add(0, 1, 64'h18, 0, 2, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 2, 64'hcccc);
        add(0, 1, 64'h20, 0, 3, 0, 0);
        add(0, 2, 64'h20, 64'habcd, 4, 0, 0);
        add(0, 1, 64'h20, 0, 5, 0, 0);
        add(0, 0, 0, 0, 0, 3, 0);
        add(0, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 5, 64'habcd);
        add(0, 1, 64'h200, 0, 0, 0, 0);
        add(0, 1, 64'h18, 0, 6, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 6, 64'hcccc);
        add(0, 1, 64'h10, 0, 7, 0, 0);
        add(0, 1, 64'h18, 0, 8, 0, 0);
        add(1, 0, 0, 0, 0, 0, 0);
        add(0, 1, 64'h18, 0, 1, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 1, 0);
        add(0, 3, 64'h10, 64'h55, 0, 0, 0);
        add(0, 1, 64'h10, 0, 2, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 2, 0);

        foreach (tbl[i]) begin
            cycle(tbl[i].rst, tbl[i].cmd, tbl[i].addr, tbl[i].data, r, t, q);
            chk("vec_resp", {60'd0, r}, {60'd0, tbl[i].resp});
            chk("vec_tag", {60'd0, t}, {60'd0, tbl[i].tag});
            chk("vec_data", q, tbl[i].rdata);
        end

        cycle(1, 0, 0, 0, r, t, q);
        for (int k = 0; k < 20; k++) begin
            if (k < 16) cycle(0, 1, 64'(k * 8), 0, r, t, q);
            else cycle(0, 0, 0, 0, r, t, q);
            if (k < 16) chk("wrap_resp", {60'd0, r}, 64'((k % 15) + 1));
            if (k >= 3 && k < 19) begin
                chk("wrap_tag", {60'd0, t}, 64'(((k - 3) % 15) + 1));
                chk("wrap_data", q, 64'd0);
            end
        end

        for (int n = 0; n < 600; n++) begin
            rc = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 9) == 0) ra = 64'h200 + 64'($urandom_range(0, 4095));
            else ra = {55'd0, 6'($urandom_range(0, 7)), 3'($urandom_range(0, 7))};
            cycle($urandom_range(0, 49) == 0, rc, ra,
                  {$urandom, $urandom}, r, t, q);
        end
        repeat (LAT + 1) cycle(0, 0, 0, 0, r, t, q);
        chk("drain", 64'(pend.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
